dpll_scheduler: RTL
===================

Name: dpll_scheduler

Overview:
- Top-level DPLL search controller. It sequences the simplification kernel (unit-clause, pure-literal and propagation loop) and a literal propagator.
- It makes branching decisions, keeps a bounded decision stack of formula snapshots, and backtracks on conflict.
- It sits between the host (start/result) and the kernel/propagator pair, which connect through request/ended handshake ports.

Parameters:
- NUM_VARS, 8, number of variables; VW = $clog2(NUM_VARS).
- NUM_CLAUSES, 8, number of clauses.
- DEPTH, 8, decision stack entries.
- FORM_W, 2*NUM_VARS*NUM_CLAUSES, formula width. Bit c*2*NUM_VARS+2*v is positive v in clause c; the +1 bit is negative v. An all-zero formula is empty (satisfied).
- LIT_W, VW+2, literal width. Bit VW+1 is valid, bit VW is negated, [VW-1:0] is the variable. All-zero means no literal.

Ports:
- clock  input  1  rising-edge clock. One clock; reset is synchronous and active-low.
- reset  input  1  synchronous active-low reset.
- start  input  1  level; sampled only in IDLE.
- in_formula  input  FORM_W  problem; captured on the start cycle.
- done  output  1  one-cycle pulse; sat/unsat are valid while done is high and hold until the next start.
- sat  output  1  satisfiable.
- unsat  output  1  unsatisfiable.
- overflow  output  1  a push was attempted with the stack full; the search aborted; sat=unsat=0.
- busy  output  1  high in every state except IDLE.
- kern_find  output  1  one-cycle request.
- kern_formula  output  FORM_W  held stable from the request until kern_ended.
- kern_ended  input  1  one-cycle completion.
- kern_sat  input  1  kernel result; valid with kern_ended.
- kern_unsat  input  1  kernel result; valid with kern_ended.
- kern_out_formula  input  FORM_W  kernel result; valid with kern_ended.
- prop_find  output  1  one-cycle request.
- prop_formula  output  FORM_W  held stable until prop_ended.
- prop_lit  output  LIT_W  held stable until prop_ended.
- prop_ended  input  1  one-cycle completion.
- prop_empty_clause  input  1  propagator result; valid with prop_ended.
- prop_empty_formula  input  1  propagator result; valid with prop_ended.
- prop_out_formula  input  FORM_W  propagator result; valid with prop_ended.

Behaviour:
- Reset (reset=0 at a clock edge): state=IDLE; stack pointer sp=0; all outputs 0; working formula and literal registers 0; counters 0.
- IDLE:
  - start=1 captures in_formula into the working register W, clears sat/unsat/overflow and sp, and goes to KSTART.
  - start is ignored in every other state.
- KSTART: drive kern_find=1 for one cycle with kern_formula=W; go to KWAIT.
- KWAIT: wait for kern_ended, then latch W<=kern_out_formula, ks<=kern_sat, ku<=kern_unsat; go to KEVAL.
- KEVAL: if ks, go to FIN_SAT; else if ku, go to BACKTRACK; else go to PICK.
- PICK:
  - Scan variables 0..NUM_VARS-1 across all clauses; the lowest index with either polarity bit set is chosen.
  - Decision literal D = {1,0,v} (positive first).
  - No variable present (W==0): go to FIN_SAT.
  - Otherwise go to PUSH.
- PUSH:
  - If sp==DEPTH, go to FIN_OVF.
  - Else store {W, D, flipped=0} at stack[sp], sp<=sp+1, L<=D; go to PSTART.
- PSTART: drive prop_find=1 for one cycle with prop_formula=W, prop_lit=L; go to PWAIT.
- PWAIT: on prop_ended, latch W<=prop_out_formula and both flags; go to PEVAL.
- PEVAL:
  - prop_empty_formula: go to FIN_SAT; this takes priority if both flags are set.
  - prop_empty_clause: go to BACKTRACK.
  - Neither: go to KSTART.
- BACKTRACK, one stack entry examined per cycle:
  - If sp==0, go to FIN_UNSAT.
  - Else read top entry e=stack[sp-1].
  - If e.flipped, then sp<=sp-1 and stay in BACKTRACK.
  - Else set e.flipped=1 in place, W<=e.formula, L<=e.lit with the negated bit inverted; go to PSTART.
- FIN_SAT, FIN_UNSAT, FIN_OVF:
  - Set the result flag, pulse done for 1 cycle, return to IDLE.
  - Flags hold until the next start.
- Minimum latency, empty input formula: start → KSTART(1) → KWAIT(kernel latency) → KEVAL → FIN_SAT → done. That is done 4 cycles after start when the kernel responds in 1 cycle.
- A kern_ended or prop_ended arriving outside its WAIT state is ignored.
- Reset asserted in any state aborts the search: next cycle is IDLE, sp=0, no done pulse.
- The stack is plain registers; the read and in-place flip happen in the same cycle; no simultaneous push and pop.

Optional Feature:
- DPLL_STATS_EN defined:
  - Adds outputs decisions[15:0] (incremented on each PUSH), backtracks[15:0] (incremented on each BACKTRACK flip) and max_depth[$clog2(DEPTH+1)-1:0].
  - All three saturate at their maximum value, clear on start and reset, and hold after done.
- Undefined: these ports and registers are absent; no other behaviour changes.

Test Plan:
- Empty-formula start; kernel stub returns kern_sat=1 one cycle later → done with sat=1, unsat=0, kern_find pulsed once, prop_find never.
- Kernel returns neither, with W containing only var 2 and var 5 → prop_lit={1,0,2}; propagator returns empty_formula → sat=1, sp=1.
- After the first decision the propagator returns empty_clause, then empty_formula on the retry → second prop_lit={1,1,2}, second prop_formula equals the pushed snapshot, sat=1, backtracks=1 (STATS).
- Both polarities of var 0 conflict with DEPTH=8 → unsat=1, sp=0, exactly 2 prop_find pulses.
- DEPTH=2; kernel always returns neither and the propagator never conflicts → overflow=1, sat=unsat=0, done pulses once after the third PICK.
- Reset driven low during PWAIT, then start issued again → outputs zero, the new run completes normally, stale prop_ended ignored.

Source files
------------

// File: rtl/dpll_scheduler.sv
// DPLL search controller: sequences the simplification kernel and literal propagator,
// keeps a bounded decision stack and backtracks on conflict. Optional statistics: DPLL_STATS_EN.
module dpll_scheduler #(
  parameter int NUM_VARS    = 8,
  parameter int NUM_CLAUSES = 8,
  parameter int DEPTH       = 8,
  localparam int VW         = $clog2(NUM_VARS),
  localparam int FORM_W     = 2 * NUM_VARS * NUM_CLAUSES,
  localparam int LIT_W      = VW + 2,
  localparam int SP_W       = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [FORM_W-1:0] in_formula,
  output logic              done,
  output logic              sat,
  output logic              unsat,
  output logic              overflow,
  output logic              busy,
  output logic              kern_find,
  output logic [FORM_W-1:0] kern_formula,
  input  logic              kern_ended,
  input  logic              kern_sat,
  input  logic              kern_unsat,
  input  logic [FORM_W-1:0] kern_out_formula,
  output logic              prop_find,
  output logic [FORM_W-1:0] prop_formula,
  output logic [LIT_W-1:0]  prop_lit,
  input  logic              prop_ended,
  input  logic              prop_empty_clause,
  input  logic              prop_empty_formula,
  input  logic [FORM_W-1:0] prop_out_formula
`ifdef DPLL_STATS_EN
  ,
  output logic [15:0]       decisions,
  output logic [15:0]       backtracks,
  output logic [SP_W-1:0]   max_depth
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LIT_W-1:0] NEG_MASK = LIT_W'(1) << VW;

  typedef enum logic [3:0] {
    S_IDLE, S_KSTART, S_KWAIT, S_KEVAL, S_PICK, S_PUSH, S_PSTART,
    S_PWAIT, S_PEVAL, S_BACKTRACK, S_FIN_SAT, S_FIN_UNSAT, S_FIN_OVF
  } state_t;

  state_t            state, state_next;
  logic [FORM_W-1:0] w;
  logic [LIT_W-1:0]  l;
  logic              ks, ku, pec, pef;
  logic [SP_W-1:0]   sp;

  logic [FORM_W-1:0] stk_form [DEPTH];
  logic [LIT_W-1:0]  stk_lit  [DEPTH];
  logic              stk_flip [DEPTH];

  logic [NUM_VARS-1:0] var_mask;
  logic [VW-1:0]       pick_var;
  logic                var_any;
  logic [LIT_W-1:0]    dec_lit;
  logic [AW-1:0]       push_idx, top_idx;
  logic                top_flip;

  logic do_capture, do_klatch, do_platch, do_push, do_pop, do_flip;

  // A variable is present if either polarity bit is set in any clause.
  always_comb begin
    var_mask = '0;
    for (int v = 0; v < NUM_VARS; v++)
      for (int c = 0; c < NUM_CLAUSES; c++)
        var_mask[v] = var_mask[v] | w[c*2*NUM_VARS + 2*v] | w[c*2*NUM_VARS + 2*v + 1];
  end

  always_comb begin
    pick_var = '0;
    for (int v = NUM_VARS - 1; v >= 0; v--)
      if (var_mask[v]) pick_var = VW'(v);
  end

  assign var_any  = |var_mask;
  assign dec_lit  = {1'b1, 1'b0, pick_var};
  assign push_idx = AW'(sp);
  assign top_idx  = AW'(sp - SP_W'(1));
  assign top_flip = stk_flip[top_idx];

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_next = state;
    do_capture = 1'b0;
    do_klatch  = 1'b0;
    do_platch  = 1'b0;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    do_flip    = 1'b0;
    case (state)
      S_IDLE:   if (start) begin do_capture = 1'b1; state_next = S_KSTART; end
      S_KSTART: state_next = S_KWAIT;
      S_KWAIT:  if (kern_ended) begin do_klatch = 1'b1; state_next = S_KEVAL; end
      S_KEVAL:  state_next = ks ? S_FIN_SAT : (ku ? S_BACKTRACK : S_PICK);
      S_PICK:   state_next = var_any ? S_PUSH : S_FIN_SAT;
      S_PUSH: begin
        if (sp == SP_W'(DEPTH)) state_next = S_FIN_OVF;
        else begin do_push = 1'b1; state_next = S_PSTART; end
      end
      S_PSTART: state_next = S_PWAIT;
      S_PWAIT:  if (prop_ended) begin do_platch = 1'b1; state_next = S_PEVAL; end
      S_PEVAL:  state_next = pef ? S_FIN_SAT : (pec ? S_BACKTRACK : S_KSTART);
      S_BACKTRACK: begin
        if (sp == '0)    state_next = S_FIN_UNSAT;
        else if (top_flip) do_pop = 1'b1;
        else begin do_flip = 1'b1; state_next = S_PSTART; end
      end
      S_FIN_SAT, S_FIN_UNSAT, S_FIN_OVF: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state    <= S_IDLE;
      w        <= '0;
      l        <= '0;
      ks       <= 1'b0;
      ku       <= 1'b0;
      pec      <= 1'b0;
      pef      <= 1'b0;
      sp       <= '0;
      sat      <= 1'b0;
      unsat    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      if (do_capture) begin
        w        <= in_formula;
        sp       <= '0;
        sat      <= 1'b0;
        unsat    <= 1'b0;
        overflow <= 1'b0;
      end
      if (do_klatch) begin
        w  <= kern_out_formula;
        ks <= kern_sat;
        ku <= kern_unsat;
      end
      if (do_platch) begin
        w   <= prop_out_formula;
        pec <= prop_empty_clause;
        pef <= prop_empty_formula;
      end
      if (do_push) begin
        sp <= sp + SP_W'(1);
        l  <= dec_lit;
      end
      if (do_pop) sp <= sp - SP_W'(1);
      if (do_flip) begin
        w <= stk_form[top_idx];
        l <= stk_lit[top_idx] ^ NEG_MASK;
      end
      // Result flags are set on entry to the FIN state so they are valid alongside done.
      if (state_next == S_FIN_SAT)   sat      <= 1'b1;
      if (state_next == S_FIN_UNSAT) unsat    <= 1'b1;
      if (state_next == S_FIN_OVF)   overflow <= 1'b1;
    end
  end

  // NOTE: the stack has no reset; entries are only read below sp, and every entry is written on push first.
  always_ff @(posedge clock) begin
    if (reset && do_push) begin
      stk_form[push_idx] <= w;
      stk_lit[push_idx]  <= dec_lit;
      stk_flip[push_idx] <= 1'b0;
    end else if (reset && do_flip) begin
      stk_flip[top_idx] <= 1'b1;
    end
  end

`ifdef DPLL_STATS_EN
  always_ff @(posedge clock) begin
    if (!reset || do_capture) begin
      decisions  <= '0;
      backtracks <= '0;
      max_depth  <= '0;
    end else begin
      if (do_push && decisions != '1)  decisions  <= decisions + 16'd1;
      if (do_flip && backtracks != '1) backtracks <= backtracks + 16'd1;
      if (do_push && (sp + SP_W'(1)) > max_depth) max_depth <= sp + SP_W'(1);
    end
  end
`endif

  assign done         = (state == S_FIN_SAT) || (state == S_FIN_UNSAT) || (state == S_FIN_OVF);
  assign busy         = (state != S_IDLE);
  assign kern_find    = (state == S_KSTART);
  assign kern_formula = w;
  assign prop_find    = (state == S_PSTART);
  assign prop_formula = w;
  assign prop_lit     = l;

endmodule
